// File: rtl/ad760x_ctrl.sv
// ============================================================================
// ad760x_ctrl
// ----------------------------------------------------------------------------
// Sequencer for an AD760x-family ADC.
//
// 1. Pulses the ADC RESET pin.
// 2. Writes a table of configuration words through an external register-write
//    SPI engine.
// 3. Free-runs conversions at a programmable sample period:
//    CONVST low, wait for BUSY to fall, then start the data-read SPI engine.
//
// It also keeps a sticky BUSY-timeout flag and a saturating count of sample
// periods that expired while a conversion was still in flight.
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-low reset
//   i_adc_busy            ADC BUSY pin
//   o_adc_cnv             CONVST, active-low
//   o_adc_rst             ADC RESET pin
//   o_adc_spi_start       1-cycle start to the data-read SPI engine
//   i_adc_spi_done        1-cycle done from the data-read SPI engine
//   o_init_spi_start      1-cycle start to the register-write SPI engine
//   i_init_spi_done       1-cycle done from the register-write SPI engine
//   o_cpol, o_cpha        SPI mode for the shared bus
//   i_adc_cyc_t           sample period in clocks (sampling disabled below
//                         P_MIN_CYC)
//   i_init_table          init words, word k at [16k+15:16k]
//   o_adc_init_data       init word currently being written
//   i_reinit              request a full reset/re-init (taken in IDLE)
//   i_err_clr             clear the timeout flag and the overrun count
//   o_ready               init complete, sampling enabled
//   o_busy_to_err         sticky BUSY timeout flag
//   o_overrun_cnt         missed-conversion count, saturating
//   o_state               current state code
// ============================================================================
module ad760x_ctrl #(
    parameter int P_N_INIT  = 4,
    parameter int P_RST_CYC = 8,
    parameter int P_CNV_CYC = 8,
    parameter int P_CNV_LOW = 3,
    parameter int P_BUSY_TO = 1000,
    parameter int P_MIN_CYC = 200
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_adc_busy,
    output logic                   o_adc_cnv,
    output logic                   o_adc_rst,
    output logic                   o_adc_spi_start,
    input  logic                   i_adc_spi_done,
    output logic                   o_init_spi_start,
    input  logic                   i_init_spi_done,
    output logic                   o_cpol,
    output logic                   o_cpha,
    input  logic [31:0]            i_adc_cyc_t,
    input  logic [16*P_N_INIT-1:0] i_init_table,
    output logic [15:0]            o_adc_init_data,
    input  logic                   i_reinit,
    input  logic                   i_err_clr,
    output logic                   o_ready,
    output logic                   o_busy_to_err,
    output logic [15:0]            o_overrun_cnt,
    output logic [3:0]             o_state
);

    typedef enum logic [3:0] {
        S_RST_PULSE = 4'd0,
        S_DELAY     = 4'd1,
        S_INIT      = 4'd2,
        S_INIT_WAIT = 4'd3,
        S_IDLE      = 4'd4,
        S_CONV      = 4'd5,
        S_BUSY      = 4'd6,
        S_SPI       = 4'd7,
        S_SPI_WAIT  = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    // Terminal counts, sized to the counters they are compared against
    localparam logic [15:0] L_RST_LAST  = 16'(P_RST_CYC - 1);
    localparam logic [15:0] L_CNV_LAST  = 16'(P_CNV_CYC - 1);
    localparam logic [15:0] L_CNV_LOW   = 16'(P_CNV_LOW);
    localparam logic [31:0] L_BUSY_LAST = 32'(P_BUSY_TO - 1);
    localparam logic [31:0] L_MIN_CYC   = 32'(P_MIN_CYC);
    localparam logic [3:0]  L_INIT_LAST = 4'(P_N_INIT - 1);

    state_t      r_state;
    logic [15:0] r_rst_cnt;
    logic [5:0]  r_dly_cnt;
    logic [3:0]  r_init_idx;
    logic [15:0] r_conv_cnt;
    logic [31:0] r_to_cnt;
    logic [31:0] r_cyc_cnt;
    logic        r_reinit_pend;
    logic        r_init_spi_start;
    logic        r_adc_spi_start;
    logic [15:0] r_adc_init_data;
    logic        r_busy_to_err;
    logic [15:0] r_overrun_cnt;

    logic        w_cyc_valid;
    logic [31:0] w_cyc_last;
    logic        w_conv_flag;
    logic        w_in_flight;
    logic [15:0] w_words [0:15];

    // ------------------------------------------------------------------
    // Init table unpacked into a 16-entry array so that any 4-bit index is
    // legal. Entries past the table read as zero, which gives the required
    // 0 output once init_idx has stepped past the last word.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_words
            if (gi < P_N_INIT) begin : g_used
                assign w_words[gi] = i_init_table[16*gi +: 16];
            end else begin : g_unused
                assign w_words[gi] = 16'h0000;
            end
        end
    endgenerate

    // Sampling is only enabled for a period long enough to fit a transaction
    assign w_cyc_valid = (i_adc_cyc_t >= L_MIN_CYC);
    assign w_cyc_last  = i_adc_cyc_t - 32'd1;
    assign w_conv_flag = w_cyc_valid && (r_cyc_cnt == w_cyc_last);
    assign w_in_flight = (r_state >= S_CONV) && (r_state <= S_DONE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state          <= S_RST_PULSE;
            r_rst_cnt        <= '0;
            r_dly_cnt        <= '0;
            r_init_idx       <= '0;
            r_conv_cnt       <= '0;
            r_to_cnt         <= '0;
            r_cyc_cnt        <= '0;
            r_reinit_pend    <= 1'b0;
            r_init_spi_start <= 1'b0;
            r_adc_spi_start  <= 1'b0;
            r_adc_init_data  <= '0;
            r_busy_to_err    <= 1'b0;
            r_overrun_cnt    <= '0;
        end else begin
            // Start strobes are one clock behind the 1-cycle issuing state
            r_init_spi_start <= (r_state == S_INIT);
            r_adc_spi_start  <= (r_state == S_SPI);
            r_adc_init_data  <= w_words[r_init_idx];

            if (i_reinit) begin
                r_reinit_pend <= 1'b1;
            end

            // Settle counter only runs while waiting in DELAY with a usable
            // sample period; it naturally wraps to 0 as DELAY exits at 63.
            if ((r_state == S_DELAY) && w_cyc_valid) begin
                r_dly_cnt <= r_dly_cnt + 6'd1;
            end else begin
                r_dly_cnt <= '0;
            end

            // Sample-period timebase runs in every state so that the
            // conversion grid stays fixed regardless of transaction length.
            // The >= keeps it in range if the period is shortened on the fly.
            if (!w_cyc_valid || (r_cyc_cnt >= w_cyc_last)) begin
                r_cyc_cnt <= '0;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end

            case (r_state)
                S_RST_PULSE: begin
                    if (r_rst_cnt == L_RST_LAST) begin
                        r_rst_cnt <= '0;
                        r_state   <= S_DELAY;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 16'd1;
                    end
                end

                S_DELAY: begin
                    if (r_dly_cnt == 6'd63) begin
                        r_state <= S_INIT;
                    end
                end

                S_INIT: begin
                    r_state <= S_INIT_WAIT;
                end

                S_INIT_WAIT: begin
                    if (i_init_spi_done) begin
                        r_init_idx <= r_init_idx + 4'd1;
                        if (r_init_idx == L_INIT_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DELAY;
                        end
                    end
                end

                S_IDLE: begin
                    if (r_reinit_pend) begin
                        // A request arriving on this very cycle stays pending
                        r_reinit_pend <= i_reinit;
                        r_init_idx    <= '0;
                        r_state       <= S_RST_PULSE;
                    end else if (w_conv_flag) begin
                        r_state <= S_CONV;
                    end
                end

                S_CONV: begin
                    if (r_conv_cnt == L_CNV_LAST) begin
                        r_conv_cnt <= '0;
                        r_state    <= S_BUSY;
                    end else begin
                        r_conv_cnt <= r_conv_cnt + 16'd1;
                    end
                end

                S_BUSY: begin
                    // BUSY falling takes priority over a coincident timeout
                    if (!i_adc_busy) begin
                        r_to_cnt <= '0;
                        r_state  <= S_SPI;
                    end else if (r_to_cnt == L_BUSY_LAST) begin
                        r_to_cnt      <= '0;
                        r_busy_to_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end

                S_SPI: begin
                    r_state <= S_SPI_WAIT;
                end

                S_SPI_WAIT: begin
                    if (i_adc_spi_done) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    // Corrupted state code: restart the ADC from scratch
                    r_reinit_pend <= i_reinit;
                    r_init_idx    <= '0;
                    r_rst_cnt     <= '0;
                    r_conv_cnt    <= '0;
                    r_to_cnt      <= '0;
                    r_state       <= S_RST_PULSE;
                end
            endcase

            // A sample period that ends while the previous conversion is
            // still in flight is a missed conversion.
            if (i_err_clr) begin
                r_overrun_cnt <= '0;
            end else if (w_conv_flag && w_in_flight && (r_overrun_cnt != 16'hFFFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 16'd1;
            end

            // Placed after the case so a clear beats a same-cycle timeout
            if (i_err_clr) begin
                r_busy_to_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    assign o_state          = r_state;
    assign o_adc_rst        = (r_state == S_RST_PULSE);
    assign o_adc_cnv        = !((r_state == S_CONV) && (r_conv_cnt < L_CNV_LOW));
    assign o_ready          = w_in_flight || (r_state == S_IDLE);
    assign o_cpol           = 1'b1;
    assign o_cpha           = (r_state >= S_IDLE);
    assign o_init_spi_start = r_init_spi_start;
    assign o_adc_spi_start  = r_adc_spi_start;
    assign o_adc_init_data  = r_adc_init_data;
    assign o_busy_to_err    = r_busy_to_err;
    assign o_overrun_cnt    = r_overrun_cnt;

endmodule

// File: doc/ad760x_ctrl.md
AD760X_CTRL -- requirements
Module: ad760x_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  P_N_INIT 4: number of init register words, 1..8
  P_RST_CYC 8: o_adc_rst high cycles on reset/re-init
  P_CNV_CYC 8: total cycles spent in CONV
  P_CNV_LOW 3: o_adc_cnv low cycles, less than P_CNV_CYC
  P_BUSY_TO 1000: BUSY timeout in clocks
  P_MIN_CYC 200: minimum valid sample period
REQ-002 Ports SHALL be (name, direction, width, meaning):
  i_clk in 1: clock
  i_rst in 1: reset, asynchronous, active-low
  i_adc_busy in 1: ADC BUSY pin
  o_adc_cnv out 1: CONVST, active-low
  o_adc_rst out 1: ADC RESET pin
  o_adc_spi_start out 1: data-read SPI start pulse
  i_adc_spi_done in 1: data-read SPI done pulse
  o_init_spi_start out 1: register-write SPI start pulse
  i_init_spi_done in 1: register-write SPI done pulse
  o_cpol out 1: SPI CPOL
  o_cpha out 1: SPI CPHA
  i_adc_cyc_t in 32: sample period in clocks
  i_init_table in 16*P_N_INIT: word k at [16k+15:16k]
  o_adc_init_data out 16: current init word
  i_reinit in 1: re-initialise request pulse
  i_err_clr in 1: clear error/overrun pulse
  o_ready out 1: init complete, sampling enabled
  o_busy_to_err out 1: sticky BUSY timeout flag
  o_overrun_cnt out 16: missed conversion count
  o_state out 4: current state code

Function
REQ-003 State codes SHALL be RST_PULSE=0, DELAY=1, INIT=2, INIT_WAIT=3, IDLE=4, CONV=5, BUSY=6, SPI=7, SPI_WAIT=8, DONE=9; o_state = state; an illegal code SHALL go to RST_PULSE.
REQ-004 RST_PULSE SHALL drive o_adc_rst=1 and, after exactly P_RST_CYC cycles, go to DELAY; o_adc_rst=0 in all other states.
REQ-005 DELAY: a 6-bit counter SHALL increment only while in DELAY with i_adc_cyc_t>=P_MIN_CYC, and SHALL read 0 otherwise; on count 63 the block SHALL go to INIT.
REQ-006 INIT SHALL last 1 cycle, then go to INIT_WAIT; o_init_spi_start SHALL be registered (state==INIT), giving a 1-cycle pulse delayed 1 clock.
REQ-007 INIT_WAIT, on i_init_spi_done: init_idx SHALL increment; if old init_idx==P_N_INIT-1, go to IDLE, else go to DELAY; i_init_spi_done outside INIT_WAIT SHALL be ignored.
REQ-008 o_adc_init_data SHALL be registered: table word[init_idx] while init_idx<P_N_INIT, else 0.
REQ-009 Period counter: cyc_cnt SHALL wrap 0..i_adc_cyc_t-1 while i_adc_cyc_t>=P_MIN_CYC, else hold 0; conv_flag = (cyc_cnt==i_adc_cyc_t-1) AND i_adc_cyc_t>=P_MIN_CYC.
REQ-010 IDLE transitions, in priority order: reinit_pend -> RST_PULSE; conv_flag -> CONV; else stay in IDLE.
REQ-011 CONV: conv_cnt SHALL count from 0; o_adc_cnv = NOT(state==CONV AND conv_cnt<P_CNV_LOW); at conv_cnt==P_CNV_CYC-1 go to BUSY.
REQ-012 BUSY: a timeout counter SHALL count from 0 in BUSY; ~i_adc_busy -> SPI; otherwise at count P_BUSY_TO-1 set o_busy_to_err and go to IDLE with no SPI start; ~i_adc_busy wins on the same cycle.
REQ-013 SPI SHALL last 1 cycle, then go to SPI_WAIT; o_adc_spi_start SHALL be registered (state==SPI). SPI_WAIT: i_adc_spi_done -> DONE; DONE -> IDLE.
REQ-014 Overrun: conv_flag while state is in CONV..DONE SHALL increment o_overrun_cnt, saturating at 16'hFFFF; conv_flag in states 0..3 SHALL NOT count.
REQ-015 i_err_clr SHALL zero o_overrun_cnt and o_busy_to_err next cycle; clear SHALL win over a simultaneous increment or set.
REQ-016 i_reinit SHALL set reinit_pend in any state; reinit_pend SHALL be acted on only in IDLE (in-flight SPI is never aborted); on entry to RST_PULSE, reinit_pend, init_idx and the delay counter SHALL clear.
REQ-017 o_ready SHALL be 1 iff state is in IDLE..DONE; o_cpol SHALL be constant 1; o_cpha SHALL be 1 iff state>=IDLE.

Reset
REQ-018 While i_rst=0, outputs SHALL be: state=RST_PULSE, all counters 0, init_idx=0, reinit_pend=0, o_adc_spi_start=0, o_init_spi_start=0, o_adc_init_data=0, o_busy_to_err=0, o_overrun_cnt=0, o_adc_cnv=1, o_adc_rst=1, o_ready=0.
REQ-019 Reset deassertion SHALL start the RST_PULSE count on the first i_clk edge; reset mid-operation SHALL abandon any transaction.

Verification
REQ-020 i_adc_cyc_t=100 -> after 8 cycles of o_adc_rst=1, state stays DELAY(1); no o_init_spi_start ever.
REQ-021 Defaults, table {1111,2222,3333,4444}, done 10 clocks after each start -> 4 start pulses; o_adc_init_data 1111,2222,3333,4444 at each start; IDLE and o_ready=1 after the 4th done.
REQ-022 i_adc_cyc_t=250, busy high 20 clocks after CONV exit, spi_done 50 clocks after start -> one CONV per 250 clocks; o_adc_cnv low exactly 3 clocks; 1-cycle o_adc_spi_start; overrun=0.
REQ-023 i_adc_busy stuck at 1 -> 1000 clocks after BUSY entry, o_busy_to_err=1, IDLE, no spi start; i_err_clr -> 0.
REQ-024 spi_done withheld across exactly two further conv_flags -> o_overrun_cnt=2; i_err_clr coincident with a third conv_flag -> 0.
REQ-025 i_reinit pulse during SPI_WAIT -> transaction completes, DONE->IDLE->RST_PULSE; o_adc_rst high 8 clocks; full init sequence reruns from word 0.
